// File: rtl/fb_scanout.sv
// fb_scanout: VGA raster timing, 2x2-upscaled frame-buffer read addressing, and sync/enable alignment to returned RAM data.
// Ports: clk/rst (async, active-high); rd_addr_o/rd_en_o drive the 320x240 RAM read port, rd_data_i returns RD_LATENCY cycles later;
// rgb_o/hsync_o/vsync_o/de_o/frame_start_o are the aligned display outputs (syncs active-low, frame_start_o marks pixel (0,0)).
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] rd_addr_o,
  output logic        rd_en_o,
  input  logic [11:0] rd_data_i,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start_o
);
  localparam int FB_W    = H_ACTIVE / 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L       = RD_LATENCY + 2;
  logic [10:0]  h_cnt, v_cnt;
  logic [16:0]  line_base;
  logic [11:0]  data_q;
  logic [L-1:0] act_d, hs_d, vs_d, fs_d;
  logic         h_end, v_end, act_raw, hs_raw, vs_raw, fs_raw;
  assign h_end   = h_cnt == 11'(H_TOTAL - 1);
  assign v_end   = v_cnt == 11'(V_TOTAL - 1);
  assign act_raw = h_cnt < 11'(H_ACTIVE) && v_cnt < 11'(V_ACTIVE);
  assign hs_raw  = !(h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw  = !(v_cnt >= 11'(V_ACTIVE + V_FP) && v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC));
  assign fs_raw  = h_cnt == '0 && v_cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
      rd_addr_o <= '0;
      rd_en_o   <= 1'b0;
      data_q    <= '0;
      act_d     <= '0;
      hs_d      <= '1;
      vs_d      <= '1;
      fs_d      <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 11'd1;
      // line_base steps one stored row only after the second (odd) copy of each active line
      if (h_end) begin
        v_cnt     <= v_end ? '0 : v_cnt + 11'd1;
        line_base <= v_end ? '0 : (v_cnt[0] && v_cnt < 11'(V_ACTIVE)) ? line_base + 17'(FB_W) : line_base;
      end
      rd_en_o <= act_raw;
      if (act_raw) rd_addr_o <= line_base + 17'(h_cnt >> 1);
      data_q <= rd_data_i;
      act_d  <= {act_d[L-2:0], act_raw};
      hs_d   <= {hs_d[L-2:0], hs_raw};
      vs_d   <= {vs_d[L-2:0], vs_raw};
      fs_d   <= {fs_d[L-2:0], fs_raw};
    end
  end
  assign de_o          = act_d[L-1];
  assign hsync_o       = hs_d[L-1];
  assign vsync_o       = vs_d[L-1];
  assign frame_start_o = fs_d[L-1];
  assign rgb_o         = de_o ? data_q : '0;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard and landmark-table bench for fb_scanout (two reduced-raster DUTs at RD_LATENCY 2/3, one full VGA DUT).
module tb_fb_scanout;
  typedef struct packed {logic de, hs, vs, fs; logic [11:0] rgb;} out_t;
  typedef struct {logic act; logic [16:0] addr; logic hs, vs, fs;} pos_t;
  typedef struct {int n; logic en; logic [16:0] addr; logic de, hs, vs, fs;} lm_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [16:0] a_addr[3];
  logic        a_en[3], a_hs[3], a_vs[3], a_de[3], a_fs[3];
  logic [11:0] a_data[3], a_rgb[3];
  logic [1:0][16:0] m0, m2;
  logic [2:0][16:0] m1;
  fb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .rd_addr_o(a_addr[0]), .rd_en_o(a_en[0]), .rd_data_i(a_data[0]), .rgb_o(a_rgb[0]),
    .hsync_o(a_hs[0]), .vsync_o(a_vs[0]), .de_o(a_de[0]), .frame_start_o(a_fs[0]));
  fb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .rd_addr_o(a_addr[1]), .rd_en_o(a_en[1]), .rd_data_i(a_data[1]), .rgb_o(a_rgb[1]),
    .hsync_o(a_hs[1]), .vsync_o(a_vs[1]), .de_o(a_de[1]), .frame_start_o(a_fs[1]));
  fb_scanout u2 (
    .clk(clk), .rst(rst), .rd_addr_o(a_addr[2]), .rd_en_o(a_en[2]), .rd_data_i(a_data[2]), .rgb_o(a_rgb[2]),
    .hsync_o(a_hs[2]), .vsync_o(a_vs[2]), .de_o(a_de[2]), .frame_start_o(a_fs[2]));
  always @(posedge clk) begin
    m0 <= {m0[0], a_addr[0]};
    m1 <= {m1[1:0], a_addr[1]};
    m2 <= {m2[0], a_addr[2]};
  end
  assign a_data[0] = m0[1][11:0];
  assign a_data[1] = m1[2][11:0];
  assign a_data[2] = m2[1][11:0];
  int n_chk = 0, n_fail = 0, p = 0;
  logic [16:0] last[3];
  logic [11:0] prev_rgb0;
  out_t q0[$], q1[$], q2[$];
  lm_t tbl[$];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at p=%0d: got %0h expected %0h", nm, p, got, exp);
    end
  endtask
  function automatic pos_t model(input int d, input int pp);
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, h, v, k;
    pos_t r;
    ha = 16; hf = 2; hsw = 4; hb = 2; va = 8; vf = 1; vsw = 2; vb = 1;
    if (d == 2) begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    k = pp % (ht * vt);
    h = k % ht;
    v = k / ht;
    r.act = h < ha && v < va;
    r.addr = 17'((v / 2) * (ha / 2) + h / 2);
    r.hs = !(h >= ha + hf && h < ha + hf + hsw);
    r.vs = !(v >= va + vf && v < va + vf + vsw);
    r.fs = k == 0;
    return r;
  endfunction
  task automatic push(input int d, input out_t o);
    case (d)
      0: q0.push_back(o);
      1: q1.push_back(o);
      default: q2.push_back(o);
    endcase
  endtask
  task automatic pop(input int d, output out_t o);
    case (d)
      0: o = q0.pop_front();
      1: o = q1.pop_front();
      default: o = q2.pop_front();
    endcase
  endtask
  task automatic restart;
    p = 0;
    q0.delete(); q1.delete(); q2.delete();
    prev_rgb0 = '0;
    for (int d = 0; d < 3; d++) begin
      last[d] = '0;
      for (int i = 0; i < (d == 1 ? 4 : 3); i++) push(d, {1'b0, 1'b1, 1'b1, 1'b0, 12'h0});
    end
  endtask
  task automatic tick;
    pos_t r;
    out_t e, g;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      r = model(d, p);
      if (r.act) last[d] = r.addr;
      chk($sformatf("rd_en%0d", d), 64'(a_en[d]), 64'(r.act));
      chk($sformatf("rd_addr%0d", d), 64'(a_addr[d]), 64'(last[d]));
      push(d, {r.act, r.hs, r.vs, r.fs, r.act ? r.addr[11:0] : 12'h0});
      pop(d, e);
      g = {a_de[d], a_hs[d], a_vs[d], a_fs[d], a_rgb[d]};
      chk($sformatf("out%0d{de,hs,vs,fs,rgb}", d), 64'(g), 64'(e));
    end
    chk("lat3_shift", 64'(a_rgb[1]), 64'(prev_rgb0));
    prev_rgb0 = a_rgb[0];
    p++;
  endtask
  task automatic rst_check;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rst_state%0d", d), 64'({a_en[d], a_addr[d], a_rgb[d], a_de[d], a_hs[d], a_vs[d], a_fs[d]}),
          64'({1'b0, 17'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
  endtask
  task automatic lm(input int n, input int en, input int a, input int de, input int hs, input int vs, input int fs);
    lm_t r;
    r.n = n; r.en = 1'(en); r.addr = 17'(a); r.de = 1'(de); r.hs = 1'(hs); r.vs = 1'(vs); r.fs = 1'(fs);
    tbl.push_back(r);
  endtask
  initial begin
    lm(1, 1, 0, 0, 1, 1, 0);    lm(3, 1, 1, 0, 1, 1, 0);    lm(4, 1, 1, 1, 1, 1, 1);
    lm(5, 1, 2, 1, 1, 1, 0);    lm(17, 0, 7, 1, 1, 1, 0);   lm(20, 0, 7, 0, 1, 1, 0);
    lm(22, 0, 7, 0, 0, 1, 0);   lm(26, 1, 0, 0, 1, 1, 0);   lm(49, 1, 8, 0, 0, 1, 0);
    lm(184, 1, 31, 1, 1, 1, 0); lm(185, 0, 31, 1, 1, 1, 0); lm(219, 0, 31, 0, 1, 1, 0);
    lm(220, 0, 31, 0, 1, 0, 0); lm(267, 0, 31, 0, 1, 0, 0); lm(268, 0, 31, 0, 1, 1, 0);
    lm(289, 1, 0, 0, 0, 1, 0);  lm(292, 1, 1, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1 rst_check();
    @(negedge clk) rst = 1'b0;
    restart();
    repeat (50) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst_check();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    restart();
    foreach (tbl[i]) begin
      while (p < tbl[i].n) tick();
      chk($sformatf("landmark_n%0d{en,addr,de,hs,vs,fs}", tbl[i].n),
          64'({a_en[0], a_addr[0], a_de[0], a_hs[0], a_vs[0], a_fs[0]}),
          64'({tbl[i].en, tbl[i].addr, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs}));
    end
    while (p < 1700) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
